// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared widths, limits and the saturating increment used by half_adder.
package half_adder_pkg;
   localparam int HA_DEFAULT_WIDTH = 1;
   localparam int HA_MAX_WIDTH     = 64;
   localparam int HA_STAT_W        = 16;
   localparam logic [HA_STAT_W-1:0] HA_STAT_SAT = 16'hFFFF;
   function automatic logic [HA_STAT_W-1:0] sat_inc(input logic [HA_STAT_W-1:0] v);
      return (v == HA_STAT_SAT) ? v : v + HA_STAT_W'(1);
   endfunction
endpackage

// File: rtl/half_adder_ha_cell.sv
// ha_cell: single-lane half adder.
module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes with a registered result path.
// Define HALF_ADDER_STATS_EN to add saturating op_count/carry_evt_count outputs.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_DEFAULT_WIDTH,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             in_valid,
   output logic [WIDTH-1:0] Sum,
   output logic [WIDTH-1:0] Carry,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             carry_any,
   output logic [CW-1:0]    carry_count
`ifdef HALF_ADDER_STATS_EN
   ,
   output logic [HA_STAT_W-1:0] op_count,
   output logic [HA_STAT_W-1:0] carry_evt_count
`endif
);
   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ha_cell u_cell (.a(A[i]), .b(B[i]), .s(Sum[i]), .c(Carry[i]));
   end

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] sum_d, carry_d;
   logic             carry_any_d, carry_any_q;
   logic [CW-1:0]    carry_count_d, carry_count_q;

   always_comb begin
      out_valid_d   = in_valid;
      sum_d         = in_valid ? Sum : sum_q;
      carry_d       = in_valid ? Carry : carry_q;
      carry_any_d   = in_valid ? |Carry : carry_any_q;
      carry_count_d = in_valid ? popcount(Carry) : carry_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         sum_q         <= '0;
         carry_q       <= '0;
         carry_any_q   <= 1'b0;
         carry_count_q <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         sum_q         <= sum_d;
         carry_q       <= carry_d;
         carry_any_q   <= carry_any_d;
         carry_count_q <= carry_count_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign carry_any   = carry_any_q;
   assign carry_count = carry_count_q;

`ifdef HALF_ADDER_STATS_EN
   logic [HA_STAT_W-1:0] op_count_d, op_count_q;
   logic [HA_STAT_W-1:0] carry_evt_count_d, carry_evt_count_q;

   always_comb begin
      op_count_d        = in_valid ? sat_inc(op_count_q) : op_count_q;
      carry_evt_count_d = (in_valid && |Carry) ? sat_inc(carry_evt_count_q) : carry_evt_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q        <= '0;
         carry_evt_count_q <= '0;
      end else begin
         op_count_q        <= op_count_d;
         carry_evt_count_q <= carry_evt_count_d;
      end
   end

   assign op_count        = op_count_q;
   assign carry_evt_count = carry_evt_count_q;
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of half_adder at WIDTH 1, 8 and 64.
module tb_half_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       a1 = 0, b1 = 0, v1 = 0;
   logic       sum1, carry1, ov1, sq1, cq1, any1;
   logic [0:0] cnt1;

   logic [7:0] a8 = 0, b8 = 0;
   logic       v8 = 0;
   logic [7:0] sum8, carry8, sq8, cq8;
   logic       ov8, any8;
   logic [3:0] cnt8;

   logic [63:0] a64 = 0, b64 = 0;
   logic        v64 = 0;
   logic [63:0] sum64, carry64, sq64, cq64;
   logic        ov64, any64;
   logic [6:0]  cnt64;

`ifdef HALF_ADDER_STATS_EN
   logic [15:0] opc1, evc1, opc8, evc8, opc64, evc64;
`endif

   half_adder #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(v1),
      .Sum(sum1), .Carry(carry1), .out_valid(ov1), .sum_q(sq1), .carry_q(cq1),
      .carry_any(any1), .carry_count(cnt1)
`ifdef HALF_ADDER_STATS_EN
      , .op_count(opc1), .carry_evt_count(evc1)
`endif
   );

   half_adder #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(v8),
      .Sum(sum8), .Carry(carry8), .out_valid(ov8), .sum_q(sq8), .carry_q(cq8),
      .carry_any(any8), .carry_count(cnt8)
`ifdef HALF_ADDER_STATS_EN
      , .op_count(opc8), .carry_evt_count(evc8)
`endif
   );

   half_adder #(.WIDTH(64)) u64 (
      .clk(clk), .rst_n(rst_n), .A(a64), .B(b64), .in_valid(v64),
      .Sum(sum64), .Carry(carry64), .out_valid(ov64), .sum_q(sq64), .carry_q(cq64),
      .carry_any(any64), .carry_count(cnt64)
`ifdef HALF_ADDER_STATS_EN
      , .op_count(opc64), .carry_evt_count(evc64)
`endif
   );

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] a, b, s, c;
      logic [3:0] n;
   } vec8_t;

   vec8_t v8_tab[3] = '{
      '{8'hF0, 8'h3C, 8'hCC, 8'h30, 4'd2},
      '{8'hFF, 8'hFF, 8'h00, 8'hFF, 4'd8},
      '{8'h0F, 8'hF0, 8'hFF, 8'h00, 4'd0}
   };

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_ov1", ov1, 0);
      check("rst_sq1", sq1, 0);
      check("rst_cq1", cq1, 0);
      check("rst_cnt8", cnt8, 0);
      check("rst_any64", any64, 0);
      // truth table runs with reset held to show the combinational path ignores it
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = 2'(i);
         #10;
         check($sformatf("tt_sum_%0d", i), sum1, (i == 1 || i == 2) ? 1 : 0);
         check($sformatf("tt_carry_%0d", i), carry1, (i == 3) ? 1 : 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a1 = 1; b1 = 1; v1 = 1;
      @(posedge clk); #1;
      check("reg_ov1", ov1, 1);
      check("reg_sq1", sq1, 0);
      check("reg_cq1", cq1, 1);
      check("reg_any1", any1, 1);
      check("reg_cnt1", cnt1, 1);
      @(negedge clk);
      v1 = 0; a1 = 0; b1 = 1;
      @(posedge clk); #1;
      check("idle_ov1", ov1, 0);
      check("idle_sq1", sq1, 0);
      check("idle_cq1", cq1, 1);
      check("idle_cnt1", cnt1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a8 = v8_tab[i].a; b8 = v8_tab[i].b; v8 = 1;
         #1;
         check($sformatf("w8_sum_%0d", i), sum8, v8_tab[i].s);
         check($sformatf("w8_carry_%0d", i), carry8, v8_tab[i].c);
         @(posedge clk); #1;
         check($sformatf("w8_ov_%0d", i), ov8, 1);
         check($sformatf("w8_sq_%0d", i), sq8, v8_tab[i].s);
         check($sformatf("w8_cq_%0d", i), cq8, v8_tab[i].c);
         check($sformatf("w8_cnt_%0d", i), cnt8, v8_tab[i].n);
         check($sformatf("w8_any_%0d", i), any8, v8_tab[i].n != 0);
      end
      @(negedge clk);
      v8 = 0;
      a64 = '1; b64 = '1; v64 = 1;
      @(posedge clk); #1;
      check("w64_cnt", cnt64, 64);
      check("w64_any", any64, 1);
      check("w64_cq", cq64, 64'hFFFF_FFFF_FFFF_FFFF);
      check("w64_sq", sq64, 0);
      check("w8_hold_cnt", cnt8, 0);
      check("w8_hold_ov", ov8, 0);
      @(negedge clk);
      v64 = 0;
      a1 = 1; b1 = 0; v1 = 1;
      @(posedge clk); #1;
      check("pre_rst_sq1", sq1, 1);
      @(negedge clk);
      a1 = 0; b1 = 1;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ov1", ov1, 0);
      check("mid_rst_sq1", sq1, 0);
      check("mid_rst_cnt64", cnt64, 0);
      check("mid_rst_any64", any64, 0);
      check("mid_rst_sum1", sum1, 1);
      a1 = 1; b1 = 1;
      #1;
      check("mid_rst_sum1b", sum1, 0);
      check("mid_rst_carry1", carry1, 1);
      @(posedge clk); #1;
      check("rst_hold_ov1", ov1, 0);
      check("rst_hold_cq1", cq1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      a1 = 0; b1 = 1; v1 = 1;
      @(posedge clk); #1;
      check("post_rst_ov1", ov1, 1);
      check("post_rst_sq1", sq1, 1);
      check("post_rst_cq1", cq1, 0);
`ifdef HALF_ADDER_STATS_EN
      @(negedge clk);
      a1 = 1; b1 = 1; v1 = 1;
      repeat (70000) @(posedge clk);
      #1;
      check("stat_op", opc1, 16'hFFFF);
      check("stat_evt", evc1, 16'hFFFF);
`endif
      @(negedge clk);
      v1 = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
